// File: rtl/mdio_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdio_master
// Purpose  : Clause-22 MDIO management master; turns one read/write command
//            into a serial MDC/MDIO frame and returns read data.
// Revision : 1.0 - initial release
// ============================================================================
module mdio_master #(
    parameter int CLK_DIV = 8,
    parameter bit PRE_EN  = 1'b1
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        cmd_req,
    input  logic        cmd_wr,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        cmd_ack,
    output logic        busy,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        rd_err,
    output logic        mdio_clk,
    output logic        mdio_out,
    output logic        mdio_out_en,
    input  logic        mdio_in
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

    state_t      r_state;
    state_t      w_state_next;
    state_t      w_start_state;
    logic [7:0]  r_div_cnt;
    logic        r_phase;
    logic [4:0]  r_bit_cnt;
    logic        r_wr;
    logic [31:0] r_shift;
    logic [15:0] r_rx;
    logic        r_ta_smp;
    logic        w_bit_end;
    logic        w_last_bit;
    logic [4:0]  w_last_idx;
    logic [31:0] w_frame;

    // Everything after the preamble; read frames carry ones from TA onward.
    assign w_frame = {2'b01, (cmd_wr ? 2'b01 : 2'b10), cmd_phy, cmd_reg,
                      (cmd_wr ? {2'b10, cmd_wdata} : 18'h3FFFF)};
    assign w_start_state = PRE_EN ? S_PRE : S_HDR;
    assign w_bit_end     = r_phase && (r_div_cnt == c_div_last);
    assign w_last_bit    = (r_bit_cnt == w_last_idx);

    always_comb begin
        w_last_idx = 5'd0;
        case (r_state)
            S_PRE:   w_last_idx = 5'd31;
            S_HDR:   w_last_idx = 5'd13;
            S_TA:    w_last_idx = 5'd1;
            S_DATA:  w_last_idx = 5'd15;
            default: w_last_idx = 5'd0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (cmd_req) w_state_next = w_start_state;
            S_PRE:  if (w_bit_end && w_last_bit) w_state_next = S_HDR;
            S_HDR:  if (w_bit_end && w_last_bit) w_state_next = S_TA;
            S_TA:   if (w_bit_end && w_last_bit) w_state_next = S_DATA;
            S_DATA: if (w_bit_end && w_last_bit) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ack     <= 1'b0;
            busy        <= 1'b0;
            rd_data     <= 16'h0000;
            rd_valid    <= 1'b0;
            rd_err      <= 1'b0;
            mdio_clk    <= 1'b0;
            mdio_out    <= 1'b1;
            mdio_out_en <= 1'b1;
            r_div_cnt   <= 8'd0;
            r_phase     <= 1'b0;
            r_bit_cnt   <= 5'd0;
            r_wr        <= 1'b0;
            r_shift     <= 32'hFFFF_FFFF;
            r_rx        <= 16'h0000;
            r_ta_smp    <= 1'b0;
        end else begin
            cmd_ack  <= 1'b0;
            rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_req) begin
                        cmd_ack     <= 1'b1;
                        busy        <= 1'b1;
                        r_wr        <= cmd_wr;
                        r_div_cnt   <= 8'd0;
                        r_phase     <= 1'b0;
                        r_bit_cnt   <= 5'd0;
                        mdio_out_en <= 1'b0;
                        // First bit is launched on the accept edge itself.
                        if (PRE_EN) begin
                            mdio_out <= 1'b1;
                            r_shift  <= w_frame;
                        end else begin
                            mdio_out <= w_frame[31];
                            r_shift  <= {w_frame[30:0], 1'b1};
                        end
                    end
                end
                S_PRE, S_HDR, S_TA, S_DATA: begin
                    if (r_div_cnt != c_div_last) begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end else begin
                        r_div_cnt <= 8'd0;
                        r_phase   <= ~r_phase;
                        mdio_clk  <= ~r_phase;
                        if (!r_phase) begin
                            if (r_state == S_TA && r_bit_cnt == 5'd1) r_ta_smp <= mdio_in;
                            if (r_state == S_DATA) r_rx <= {r_rx[14:0], mdio_in};
                        end else if (w_state_next == S_DONE) begin
                            busy        <= 1'b0;
                            mdio_out    <= 1'b1;
                            mdio_out_en <= 1'b1;
                            if (!r_wr) begin
                                rd_valid <= 1'b1;
                                rd_data  <= r_rx;
                                rd_err   <= r_ta_smp;
                            end
                        end else begin
                            r_bit_cnt <= (w_state_next == r_state) ? r_bit_cnt + 5'd1 : 5'd0;
                            if (w_state_next == S_PRE) begin
                                mdio_out <= 1'b1;
                            end else begin
                                mdio_out <= r_shift[31];
                                r_shift  <= {r_shift[30:0], 1'b1};
                            end
                            mdio_out_en <= !r_wr && (w_state_next == S_TA || w_state_next == S_DATA);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
